// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: data/address widths and the
// writeback arbiter state encoding.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-load bitmap: a register is busy from the cycle its load issues until
// the load's data has been written back. x0 is never marked busy.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // One-hot set/clear masks for this cycle's issue and writeback
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_valid)                     clr_mask[clr_addr] = 1'b1;
  end

  // Set is applied after clear so a reissue in the retire cycle stays busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_mask) | set_mask;
  end

  assign rs1_busy = pending_q[rs1_addr];
  assign rs2_busy = pending_q[rs2_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and LSU writeback requests onto
// a single registered write port. The LSU normally has priority; an ALU that
// has been denied STARVE_LIMIT consecutive cycles is forced through next.
// Optional load scoreboard is built when RF_WB_SCOREBOARD_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_NORMAL | LSU has priority, ALU granted only when LSU idle
// ST_FORCE  | ALU starved; only the ALU may be granted until it transfers
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
`ifdef RF_WB_SCOREBOARD_EN
  ,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_state_e  state_q, state_d;
  logic [3:0] starve_q, starve_d;

  // Grant decision; depends only on valids and arbiter state
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (state_q == ST_FORCE) alu_ready = alu_valid;
      else if (lsu_valid)      lsu_ready = 1'b1;
      else                     alu_ready = alu_valid;
    end
  end

  // Starvation counter and NORMAL/FORCE transitions
  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (alu_ready) begin
      starve_d = 4'd0;
      state_d  = ST_NORMAL;
    end else if (alu_valid) begin
      if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
      if ((state_q == ST_NORMAL) && (starve_d >= LIMIT)) state_d = ST_FORCE;
    end else begin
      starve_d = 4'd0;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Registered write port; x0 writes complete the handshake but never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (lsu_ready && (lsu_addr != '0)) || (alu_ready && (alu_addr != '0));
      if (lsu_ready) begin
        rf_waddr <= lsu_addr;
        rf_wdata <= lsu_data;
      end else if (alu_ready) begin
        rf_waddr <= alu_addr;
        rf_wdata <= alu_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic wb_from_lsu_q;

  // Remember which requester owns the write currently on the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wb_from_lsu_q <= 1'b0;
    else if (lsu_ready) wb_from_lsu_q <= 1'b1;
    else if (alu_ready) wb_from_lsu_q <= 1'b0;
  end

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_addr  (issue_addr),
    .clr_valid (rf_we && wb_from_lsu_q),
    .clr_addr  (rf_waddr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized requesters, all checked against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_addr = '0, lsu_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RF_WB_SCOREBOARD_EN
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0, rs1_addr = '0, rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
`endif

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_WB_SCOREBOARD_EN
    , .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: priority rule, consecutive-denial count, one-deep
  // writeback pipeline and pending-load set.
  bit          m_forced = 0;
  int          m_denied = 0;
  bit          exp_we = 0;
  bit          exp_lsu = 0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  bit          m_pend [32];
  bit          g_alu, g_lsu;
  bit          dut_alu_r, dut_lsu_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_forced = 0;
    m_denied = 0;
    exp_we   = 0;
    exp_lsu  = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  // One clock: compare at negedge, advance model at posedge, return at +1
  task automatic cycle();
    @(negedge clk);
    g_alu = 0;
    g_lsu = 0;
    if (m_forced)       g_alu = alu_valid;
    else if (lsu_valid) g_lsu = 1;
    else                g_alu = alu_valid;
    dut_alu_r = alu_ready;
    dut_lsu_r = lsu_ready;
    chk("alu_ready", alu_ready, g_alu);
    chk("lsu_ready", lsu_ready, g_lsu);
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, exp_waddr);
      chk("rf_wdata", rf_wdata, exp_wdata);
    end
`ifdef RF_WB_SCOREBOARD_EN
    chk("rs1_busy", rs1_busy, (rs1_addr != 0) && m_pend[rs1_addr]);
    chk("rs2_busy", rs2_busy, (rs2_addr != 0) && m_pend[rs2_addr]);
`endif
    @(posedge clk);
`ifdef RF_WB_SCOREBOARD_EN
    if (exp_we && exp_lsu) m_pend[exp_waddr] = 0;
    if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
`endif
    exp_we = 0;
    if (g_lsu) begin
      exp_we = (lsu_addr != 0); exp_waddr = lsu_addr; exp_wdata = lsu_data; exp_lsu = 1;
    end else if (g_alu) begin
      exp_we = (alu_addr != 0); exp_waddr = alu_addr; exp_wdata = alu_data; exp_lsu = 0;
    end
    if (g_alu) begin
      m_denied = 0;
      m_forced = 0;
    end else if (alu_valid) begin
      m_denied++;
      if (m_denied >= LIMIT) m_forced = 1;
    end else begin
      m_denied = 0;
    end
    #1;
  endtask

  initial begin
    int n;
    model_reset();

    // Reset: outputs clear and no ready even with requests present
    alu_valid = 1; lsu_valid = 1;
    #3;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    alu_valid = 0; lsu_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("t1_alu_ready", dut_alu_r, 1);
    alu_valid = 0;
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    cycle();

    // Collision: LSU first, ALU next cycle
    lsu_valid = 1; lsu_addr = 3; lsu_data = 32'h11;
    alu_valid = 1; alu_addr = 4; alu_data = 32'h22;
    cycle();
    chk("col_lsu_first", dut_lsu_r, 1);
    lsu_valid = 0;
    chk("col_w1_addr", rf_waddr, 3);
    chk("col_w1_data", rf_wdata, 32'h11);
    cycle();
    chk("col_alu_second", dut_alu_r, 1);
    alu_valid = 0;
    chk("col_w2_addr", rf_waddr, 4);
    chk("col_w2_data", rf_wdata, 32'h22);
    cycle();

    // Starvation: ALU forced on the 4th cycle, LSU resumes after
    lsu_valid = 1; lsu_addr = 12; lsu_data = 32'hA0;
    alu_valid = 1; alu_addr = 10; alu_data = 32'hC0FFEE;
    n = 0;
    while (n < 10) begin
      cycle();
      n++;
      if (dut_alu_r) break;
      lsu_data = lsu_data + 1;
    end
    chk("starve_grant_cycle", n, 4);
    alu_valid = 0;
    cycle();
    chk("starve_lsu_resume", dut_lsu_r, 1);
    lsu_valid = 0;
    cycle();

    // Write to x0: handshake completes, no register write
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
    cycle();
    chk("x0_alu_ready", dut_alu_r, 1);
    alu_valid = 0;
    chk("x0_no_we", rf_we, 0);
    cycle();

`ifdef RF_WB_SCOREBOARD_EN
    // Scoreboard: busy until the LSU write appears, reissue keeps it busy
    issue_valid = 1; issue_addr = 7; rs1_addr = 7;
    cycle();
    issue_valid = 0;
    #1 chk("sb_busy_set", rs1_busy, 1);
    lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
    cycle();
    lsu_valid = 0;
    chk("sb_busy_during_we", rs1_busy, 1);
    cycle();
    chk("sb_busy_cleared", rs1_busy, 0);
    issue_valid = 1; issue_addr = 7;
    cycle();
    issue_valid = 0;
    lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h78;
    cycle();
    lsu_valid = 0;
    issue_valid = 1; issue_addr = 7;
    cycle();
    issue_valid = 0;
    chk("sb_reissue_busy", rs1_busy, 1);
    cycle();
`endif

    // Async reset between grant and write: in-flight write discarded
    alu_valid = 1; alu_addr = 9; alu_data = 32'h12345678;
`ifdef RF_WB_SCOREBOARD_EN
    issue_valid = 1; issue_addr = 9; rs1_addr = 9;
`endif
    cycle();
    alu_valid = 0;
`ifdef RF_WB_SCOREBOARD_EN
    issue_valid = 0;
    chk("rstmid_busy_before", rs1_busy, 1);
`endif
    chk("rstmid_we_before", rf_we, 1);
    #1 rst = 1;
    #1;
    chk("rstmid_we_now", rf_we, 0);
`ifdef RF_WB_SCOREBOARD_EN
    chk("rstmid_busy_now", rs1_busy, 0);
`endif
    alu_valid = 1;
    #1 chk("rstmid_no_ready", alu_ready, 0);
    alu_valid = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rstmid_no_write", rf_we, 0);

    // Randomized requesters that hold requests until accepted
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (g_alu || !alu_valid) begin
        alu_valid = ($urandom_range(0, 99) < 55);
        alu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data  = $urandom;
      end
      if (g_lsu || !lsu_valid) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_addr  = ($urandom_range(0, 3) == 0) ? alu_addr : 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
`ifdef RF_WB_SCOREBOARD_EN
      issue_valid = ($urandom_range(0, 99) < 20);
      issue_addr  = ($urandom_range(0, 1) == 0) ? lsu_addr : 5'($urandom_range(0, 31));
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = ($urandom_range(0, 1) == 0) ? issue_addr : 5'($urandom_range(0, 31));
`endif
    end
    alu_valid = 0; lsu_valid = 0;
`ifdef RF_WB_SCOREBOARD_EN
    issue_valid = 0;
`endif
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive denied ALU-valid cycles before the ALU is forced a grant (range 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock, all state on posedge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports alu_valid in 1, alu_ready out 1, alu_addr in 5, alu_data in 32: ALU writeback request.
REQ-005 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_addr in 5, lsu_data in 32: load writeback request.
REQ-006 SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out 32: register-file write port 3, all registered.
REQ-007 SHALL have ports issue_valid in 1, issue_addr in 5 (load issued to rd), rs1_addr in 5, rs2_addr in 5, rs1_busy out 1, rs2_busy out 1, present only under RF_WB_SCOREBOARD_EN.

Function
REQ-008 SHALL transfer a request when valid && ready at a posedge; requesters hold valid/addr/data stable until transfer.
REQ-009 SHALL assert at most one of alu_ready/lsu_ready per cycle; ready is combinational from valids and arbiter state, never from rf_* outputs.
REQ-010 SHALL have FSM states NORMAL (LSU priority) and FORCE (ALU priority).
REQ-011 SHALL in NORMAL grant LSU if lsu_valid, else ALU if alu_valid, else none.
REQ-012 SHALL keep 4-bit starve counter: +1 each cycle alu_valid && !alu_ready; cleared when ALU transfers or alu_valid low.
REQ-013 SHALL move NORMAL->FORCE on the edge where the counter reaches STARVE_LIMIT; FORCE grants ALU only; FORCE->NORMAL on ALU transfer, clearing counter.
REQ-014 SHALL present a transfer at cycle N on rf_we/rf_waddr/rf_wdata in cycle N+1 (latency 1); rf_we=0 on cycles with no transfer.
REQ-015 SHALL accept writes to address 0 (handshake completes) but keep rf_we=0 for them.
REQ-016 SHALL preserve grant order for back-to-back writes to the same address (later grant's data wins in the file).
REQ-017 SHALL, with scoreboard: set pending[a] on issue_valid (a!=0); clear pending[a] in the cycle rf_we is high for an LSU-sourced write to a.
REQ-018 SHALL let set win over clear on the same address in the same cycle.
REQ-019 SHALL drive rsN_busy = pending[rsN_addr] combinationally; address 0 never busy.

Reset
REQ-020 SHALL on rst: rf_we=0, rf_waddr=0, rf_wdata=0, state NORMAL, counter 0, pending all 0.
REQ-021 SHALL drive alu_ready=lsu_ready=0 while rst is high.
REQ-022 SHALL discard an in-flight registered write when rst asserts mid-operation; rsN_busy reads 0 the same cycle.

Configuration
REQ-023 SHALL compile the scoreboard (REQ-007, 017-019) only when RF_WB_SCOREBOARD_EN is defined; without it those ports and the pending state do not exist and arbitration is unchanged.

Structure
REQ-024 SHALL take XLEN=32, REG_ADDR_W=5 and the FSM state enum from shared package rf_pkg.
REQ-025 SHALL place the pending bitmap in sub-module rf_scoreboard, instantiated only under RF_WB_SCOREBOARD_EN.

Verification
REQ-026 SHALL test single ALU write: alu_valid, addr 5, data 0xDEADBEEF -> alu_ready same cycle, next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-027 SHALL test collision: both valid, LSU addr 3 data 0x11, ALU addr 4 data 0x22 -> LSU granted first, rf writes 3 then 4 on consecutive cycles.
REQ-028 SHALL test starvation with STARVE_LIMIT=3: lsu_valid held high, alu_valid high -> ALU granted exactly on the 4th cycle, LSU resumes next cycle.
REQ-029 SHALL test x0: ALU write to addr 0 data 0xFFFFFFFF -> alu_ready=1, rf_we stays 0.
REQ-030 SHALL test scoreboard: issue_valid addr 7 -> rs1_addr=7 busy=1 until LSU write to 7 appears on rf_we, busy=0 next cycle; simultaneous reissue to 7 keeps busy=1.
REQ-031 SHALL test async reset mid-transfer: rst pulsed between grant and write cycle -> rf_we=0 immediately, no write, pending cleared.
